// File: rtl/rgb_fade_pkg.sv
// Shared types and widths for the RGB fade sequencer.
package rgb_fade_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned N_CH  = 3;
  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FADE
  } state_e;

endpackage

// File: rtl/rgb_fade_sequencer_tick_prescaler.sv
// Free-running tick prescaler.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : count enable; counter is held at zero while low
//   tick : one-cycle pulse on the cycle the counter wraps from PRESCALE-1
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Palette fade sequencer feeding a 3-channel PWM block.
// Holds each palette entry for HOLD_TICKS ticks, then ramps every channel
// linearly by STEP per tick toward the next entry, wrapping around the palette.
//   clk, rst          : clock, synchronous active-high reset
//   start / stop      : begin at palette[0] from IDLE / abort to IDLE (stop wins)
//   wr_en/addr/data   : palette write port, {ch2, ch1, ch0}
//   busy              : high in HOLD or FADE
//   color_idx         : index of the palette entry last reached
//   pwm_en            : one-cycle load strobe, the cycle after any value change
//   value0..value2    : registered duty values for channels 0..2
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1024,
  parameter int unsigned PAL_DEPTH  = 4,
  parameter int unsigned HOLD_TICKS = 64,
  parameter int unsigned STEP       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         wr_en,
  input  logic [$clog2(PAL_DEPTH)-1:0] wr_addr,
  input  logic [23:0]                  wr_data,
  output logic                         busy,
  output logic [$clog2(PAL_DEPTH)-1:0] color_idx,
  output logic                         pwm_en,
  output logic [7:0]                   value0,
  output logic [7:0]                   value1,
  output logic [7:0]                   value2
);

  localparam int unsigned IDX_W  = $clog2(PAL_DEPTH);
  localparam int unsigned HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
  localparam logic [CH_W:0]     STEP9     = (CH_W + 1)'(STEP);

  state_e             state_q, state_d;
  logic [RGB_W-1:0]   val_q, val_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [RGB_W-1:0]   pal_q [PAL_DEPTH];
  logic [RGB_W-1:0]   pal_d [PAL_DEPTH];
  logic               chg_q, chg_d;
  logic               pwm_en_q, pwm_en_d;

  logic               run, tick;
  logic [IDX_W-1:0]   nxt_idx;
  logic [RGB_W-1:0]   target;
  logic [RGB_W-1:0]   stepped;

  assign run = (state_q != IDLE) && !stop;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // Target is read live from the palette so writes redirect an active ramp.
  assign nxt_idx = idx_q + IDX_W'(1);
  assign target  = pal_q[nxt_idx];

  // 9-bit distance compare per channel: snap when within STEP, else move STEP.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CH_W:0] cur, tgt, res;
    always_comb begin
      cur = {1'b0, val_q[g*CH_W +: CH_W]};
      tgt = {1'b0, target[g*CH_W +: CH_W]};
      if (tgt >= cur) res = ((tgt - cur) <= STEP9) ? tgt : cur + STEP9;
      else            res = ((cur - tgt) <= STEP9) ? tgt : cur - STEP9;
    end
    assign stepped[g*CH_W +: CH_W] = res[CH_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pal_d   = pal_q;
    if (wr_en) pal_d[wr_addr] = wr_data;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            val_d   = pal_q[0];
            idx_d   = '0;
            hold_d  = HOLD_INIT;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_q == '0) state_d = FADE;
            else              hold_d  = hold_q - HOLD_W'(1);
          end
        end
        FADE: begin
          if (tick) begin
            val_d = stepped;
            if (stepped == target) begin
              idx_d   = nxt_idx;
              hold_d  = HOLD_INIT;
              state_d = HOLD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Strobe trails the value update by one cycle so the PWM loads settled data.
    chg_d    = (val_d != val_q);
    pwm_en_d = chg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      val_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      chg_q    <= 1'b0;
      pwm_en_q <= 1'b0;
      for (int unsigned i = 0; i < PAL_DEPTH; i++) pal_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      chg_q    <= chg_d;
      pwm_en_q <= pwm_en_d;
      pal_q    <= pal_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign color_idx = idx_q;
  assign pwm_en    = pwm_en_q;
  assign value0    = val_q[7:0];
  assign value1    = val_q[15:8];
  assign value2    = val_q[23:16];

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer with PRESCALE=4, PAL_DEPTH=4,
// HOLD_TICKS=2, STEP=16. Fade ticks land 4*k edges after the start edge.
module tb_rgb_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, pwm_en;
  logic [1:0]  color_idx;
  logic [7:0]  value0, value1, value2;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(
    .PRESCALE   (4),
    .PAL_DEPTH  (4),
    .HOLD_TICKS (2),
    .STEP       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .color_idx (color_idx),
    .pwm_en    (pwm_en),
    .value0    (value0),
    .value1    (value1),
    .value2    (value2)
  );

  typedef struct {
    int          at;      // edge index relative to the run's first edge
    logic [3:0]  ctl;     // {start, stop, rst, wr_en} held for the cycle before 'at'
    logic [1:0]  addr;
    logic [23:0] data;
    logic [23:0] rgb;     // expected {value2, value1, value0}
    logic [1:0]  idx;
    logic        busy;
    logic        pwm;
  } vec_t;

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  idx;
    logic        busy;
    logic        pwm;
  } exp_t;

  localparam logic [3:0] N = 4'b0000, S = 4'b1000, P = 4'b0100,
                         R = 4'b0010, W = 4'b0001;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   pwm_cnt = 0;
  exp_t sb[$];
  vec_t tbl1[18];
  vec_t tbl2[8];

  always @(posedge clk) if (pwm_en) pwm_cnt <= pwm_cnt + 1;

  function automatic vec_t mk(int at, logic [3:0] ctl, logic [1:0] a, logic [23:0] d,
                              logic [23:0] rgb, logic [1:0] idx, logic b, logic p);
    vec_t v;
    v.at = at; v.ctl = ctl; v.addr = a; v.data = d;
    v.rgb = rgb; v.idx = idx; v.busy = b; v.pwm = p;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(vec_t v, int base, string nm);
    exp_t e;
    while (cyc < base + v.at - 1) step();
    {start, stop, rst, wr_en} = v.ctl;
    wr_addr = v.addr;
    wr_data = v.data;
    e.rgb = v.rgb; e.idx = v.idx; e.busy = v.busy; e.pwm = v.pwm;
    sb.push_back(e);
    step();
    {start, stop, rst, wr_en} = N;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", nm);
    end else begin
      e = sb.pop_front();
      check({nm, ".rgb"},  {8'h0, value2, value1, value0}, {8'h0, e.rgb});
      check({nm, ".idx"},  {30'h0, color_idx}, {30'h0, e.idx});
      check({nm, ".busy"}, {31'h0, busy}, {31'h0, e.busy});
      check({nm, ".pwm"},  {31'h0, pwm_en}, {31'h0, e.pwm});
    end
  endtask

  initial begin
    int base;
    int pwm0;
    logic [23:0] pal_init [4];

    // Palette 0 -> 1 ramps ch0 by 16/tick; 1 -> 2 identical; 2 -> 3 saturates +8.
    pal_init[0] = 24'hFF0000;
    pal_init[1] = 24'hFF00F0;
    pal_init[2] = 24'hFF00F0;
    pal_init[3] = 24'hFF00F8;

    tbl1[0]  = mk(  0, S, 0, 0, 24'hFF0000, 0, 1, 0);
    tbl1[1]  = mk(  1, N, 0, 0, 24'hFF0000, 0, 1, 1);
    tbl1[2]  = mk(  2, N, 0, 0, 24'hFF0000, 0, 1, 0);
    tbl1[3]  = mk( 15, N, 0, 0, 24'hFF0000, 0, 1, 0);
    tbl1[4]  = mk( 16, N, 0, 0, 24'hFF0010, 0, 1, 0);
    tbl1[5]  = mk( 17, N, 0, 0, 24'hFF0010, 0, 1, 1);
    tbl1[6]  = mk( 32, N, 0, 0, 24'hFF0050, 0, 1, 0);
    tbl1[7]  = mk( 71, N, 0, 0, 24'hFF00E0, 0, 1, 0);
    tbl1[8]  = mk( 72, N, 0, 0, 24'hFF00F0, 1, 1, 0);
    tbl1[9]  = mk( 74, S, 0, 0, 24'hFF00F0, 1, 1, 0);
    tbl1[10] = mk( 88, N, 0, 0, 24'hFF00F0, 2, 1, 0);
    tbl1[11] = mk( 89, N, 0, 0, 24'hFF00F0, 2, 1, 0);
    tbl1[12] = mk(104, N, 0, 0, 24'hFF00F8, 3, 1, 0);
    tbl1[13] = mk(120, N, 0, 0, 24'hFF00E8, 3, 1, 0);
    tbl1[14] = mk(124, N, 0, 0, 24'hFF00D8, 3, 1, 0);
    tbl1[15] = mk(126, P, 0, 0, 24'hFF00D8, 3, 0, 0);
    tbl1[16] = mk(140, N, 0, 0, 24'hFF00D8, 3, 0, 0);
    tbl1[17] = mk(141, S | P, 0, 0, 24'hFF00D8, 3, 0, 0);

    tbl2[0] = mk( 0, S, 0, 0,          24'hFF0000, 0, 1, 0);
    tbl2[1] = mk(16, N, 0, 0,          24'hFF0010, 0, 1, 0);
    tbl2[2] = mk(17, W, 1, 24'hFF0008, 24'hFF0010, 0, 1, 1);
    tbl2[3] = mk(20, N, 0, 0,          24'hFF0008, 1, 1, 0);
    tbl2[4] = mk(36, N, 0, 0,          24'hFF0018, 1, 1, 0);
    tbl2[5] = mk(37, R, 0, 0,          24'h000000, 0, 0, 0);
    tbl2[6] = mk(40, S, 0, 0,          24'h000000, 0, 1, 0);
    tbl2[7] = mk(41, N, 0, 0,          24'h000000, 0, 1, 0);

    rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset.rgb",  {8'h0, value2, value1, value0}, 32'h0);
    check("reset.pwm",  {31'h0, pwm_en}, 32'h0);
    check("reset.busy", {31'h0, busy}, 32'h0);
    check("reset.idx",  {30'h0, color_idx}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = pal_init[i];
      step();
    end
    wr_en = 1'b0;

    pwm0 = pwm_cnt;
    base = cyc + 1;
    for (int i = 0; i < 18; i++) run_vec(tbl1[i], base, $sformatf("run1[%0d]", i));
    // 1 load + 15 ramp steps + saturate + 2 wrap steps
    check("run1.pwm_pulses", 32'(pwm_cnt - pwm0), 32'd19);

    base = cyc + 1;
    for (int i = 0; i < 8; i++) run_vec(tbl2[i], base, $sformatf("run2[%0d]", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
